// File: rtl/uart_load_ctrl.sv
// UART monitor-protocol sequencer: parses WRITE/RUN/HALT bytes, issues word writes, drives core reset.
// Optional trailing XOR checksum on WRITE when UART_LOAD_CHECKSUM_EN is defined.
module uart_load_ctrl #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic        CPU_RST_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_block_timeout,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              cmd_done,
    output logic [1:0]        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef UART_LOAD_CHECKSUM_EN
        S_CSUM,
`endif
        S_WR
    } state_t;

    state_t            state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [8:0]        word_cnt, word_cnt_n;
    logic [23:0]       addr_sh, addr_sh_n;
    logic [23:0]       word_sh, word_sh_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n;
    logic              mem_wr_valid_n, cpu_rst_n, cmd_done_n;
    logic              abort, abort_n;
    logic [1:0]        err_n;
    logic              rx_byte;
    logic [31:0]       addr_full;

    // A timeout in the same cycle as a byte drops the byte
    assign rx_byte   = rx_data_valid & ~rx_block_timeout;
    assign busy      = (state != S_IDLE);
    assign addr_full = {rx_data, addr_sh};

`ifdef UART_LOAD_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            csum <= '0;
        end else if (rx_byte && (state == S_ADDR || state == S_LEN || state == S_DATA)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            addr_sh      <= '0;
            word_sh      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wr_valid <= 1'b0;
            cpu_rst      <= CPU_RST_INIT;
            cmd_done     <= 1'b0;
            abort        <= 1'b0;
            err          <= '0;
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            word_cnt     <= word_cnt_n;
            addr_sh      <= addr_sh_n;
            word_sh      <= word_sh_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            mem_wr_valid <= mem_wr_valid_n;
            cpu_rst      <= cpu_rst_n;
            cmd_done     <= cmd_done_n;
            abort        <= abort_n;
            err          <= err_n;
        end
    end

    always_comb begin
        state_n        = state;
        byte_cnt_n     = byte_cnt;
        word_cnt_n     = word_cnt;
        addr_sh_n      = addr_sh;
        word_sh_n      = word_sh;
        mem_addr_n     = mem_addr;
        mem_wdata_n    = mem_wdata;
        mem_wr_valid_n = mem_wr_valid;
        cpu_rst_n      = cpu_rst;
        cmd_done_n     = 1'b0;
        abort_n        = abort;
        err_n          = err;

        case (state)
            S_IDLE: begin
                if (rx_byte) begin
                    case (rx_data)
                        8'h01: begin
                            state_n    = S_ADDR;
                            byte_cnt_n = '0;
                            abort_n    = 1'b0;
                            err_n      = '0;
                        end
                        8'h02: begin
                            cpu_rst_n  = 1'b0;
                            cmd_done_n = 1'b1;
                            err_n      = '0;
                        end
                        8'h03: begin
                            cpu_rst_n  = 1'b1;
                            cmd_done_n = 1'b1;
                            err_n      = '0;
                        end
                        default: err_n = 2'd1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_block_timeout) begin
                    err_n   = 2'd2;
                    state_n = S_IDLE;
                end else if (rx_byte) begin
                    addr_sh_n  = addr_full[31:8];
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_addr_n = addr_full[ADDR_W-1:0];
                        state_n    = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (rx_block_timeout) begin
                    err_n   = 2'd2;
                    state_n = S_IDLE;
                end else if (rx_byte) begin
                    word_cnt_n = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    byte_cnt_n = '0;
                    state_n    = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_block_timeout) begin
                    err_n   = 2'd2;
                    state_n = S_IDLE;
                end else if (rx_byte) begin
                    word_sh_n  = {rx_data, word_sh[23:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_wdata_n    = {rx_data, word_sh};
                        mem_wr_valid_n = 1'b1;
                        state_n        = S_WR;
                    end
                end
            end
            S_WR: begin
                // Errors here are recorded at once; the pending write still completes
                if (rx_block_timeout) begin
                    err_n   = 2'd2;
                    abort_n = 1'b1;
                end else if (rx_data_valid) begin
                    err_n   = 2'd3;
                    abort_n = 1'b1;
                end
                if (mem_wr_ready) begin
                    mem_wr_valid_n = 1'b0;
                    mem_addr_n     = mem_addr + ADDR_W'(4);
                    word_cnt_n     = word_cnt - 9'd1;
                    byte_cnt_n     = '0;
                    if (abort_n) begin
                        abort_n = 1'b0;
                        state_n = S_IDLE;
                    end else if (word_cnt == 9'd1) begin
`ifdef UART_LOAD_CHECKSUM_EN
                        state_n = S_CSUM;
`else
                        state_n    = S_IDLE;
                        cmd_done_n = 1'b1;
`endif
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
`ifdef UART_LOAD_CHECKSUM_EN
            S_CSUM: begin
                if (rx_block_timeout) begin
                    err_n   = 2'd2;
                    state_n = S_IDLE;
                end else if (rx_byte) begin
                    if (rx_data == csum) cmd_done_n = 1'b1;
                    else                 err_n      = 2'd3;
                    state_n = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed bench for uart_load_ctrl; also exercises the checksum path when UART_LOAD_CHECKSUM_EN is defined.
module tb_uart_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_block_timeout = 1'b0;
    logic        mem_wr_ready = 1'b0;
    logic        mem_wr_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        cmd_done;
    logic [1:0]  err;

    int unsigned nvec = 0;
    int unsigned nmis = 0;
    int unsigned done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  tb_csum = 8'h00;

    always #5 clk = ~clk;

    uart_load_ctrl #(
        .ADDR_W(32),
        .CPU_RST_INIT(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data_valid(rx_data_valid),
        .rx_data(rx_data),
        .rx_block_timeout(rx_block_timeout),
        .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .cmd_done(cmd_done),
        .err(err)
    );

    // Inputs change just after posedge, so negedge sees what the next posedge will use
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_valid && mem_wr_ready) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
            end
            if (cmd_done) done_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        send_byte(b);
        tick();
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [7:0] n);
        logic [7:0] b;
        send_b(8'h01);
        tb_csum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b = a[8*i +: 8];
            send_b(b);
            tb_csum ^= b;
        end
        send_b(n);
        tb_csum ^= n;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            send_b(b);
            tb_csum ^= b;
        end
    endtask

    initial begin
        int unsigned d0;
        int unsigned w0;
        logic        stable;
        logic [7:0]  b;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(mem_wr_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);

        // RUN / HALT
        send_byte(8'h02);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_done", 32'(cmd_done), 32'd1);
        tick();
        chk("run_done_pulse", 32'(cmd_done), 32'd0);
        send_byte(8'h03);
        chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        chk("halt_done_cnt", done_cnt, 32'd2);

        // WRITE N=2 with ready tied high
        mem_wr_ready = 1'b1;
        d0 = done_cnt;
        w0 = 32'(wa.size());
        send_hdr(32'h0000_0100, 8'd2);
        chk("wr_busy", 32'(busy), 32'd1);
        send_b(8'h11); send_b(8'h22); send_b(8'h33);
        tb_csum ^= 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
        send_byte(8'h44);
        chk("wr_latency_valid", 32'(mem_wr_valid), 32'd1);
        chk("wr_latency_addr", mem_addr, 32'h0000_0100);
        chk("wr_latency_data", mem_wdata, 32'h4433_2211);
        tick();
        send_word(32'h8877_6655);
`ifdef UART_LOAD_CHECKSUM_EN
        chk("csum_value", 32'(tb_csum), 32'h8B);
        chk("csum_wait_busy", 32'(busy), 32'd1);
        send_b(tb_csum);
`endif
        tick();
        chk("wr_count", 32'(wa.size()) - w0, 32'd2);
        chk("wr0_addr", wa[w0], 32'h0000_0100);
        chk("wr0_data", wd[w0], 32'h4433_2211);
        chk("wr1_addr", wa[w0+1], 32'h0000_0104);
        chk("wr1_data", wd[w0+1], 32'h8877_6655);
        chk("wr_done_once", done_cnt - d0, 32'd1);
        chk("wr_busy_end", 32'(busy), 32'd0);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_cpu_rst_kept", 32'(cpu_rst), 32'd1);

        // Backpressure with an overrun byte during the stall
        mem_wr_ready = 1'b0;
        d0 = done_cnt;
        w0 = 32'(wa.size());
        send_hdr(32'h0000_0200, 8'd1);
        send_word(32'hDDCC_BBAA);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) send_byte(8'h55);
            else         tick();
            if (mem_wr_valid !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'hDDCC_BBAA)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_overrun_err", 32'(err), 32'd3);
        chk("bp_no_write_yet", 32'(wa.size()) - w0, 32'd0);
        mem_wr_ready = 1'b1;
        tick();
        tick();
        chk("bp_write", 32'(wa.size()) - w0, 32'd1);
        chk("bp_write_data", wd[w0], 32'hDDCC_BBAA);
        chk("bp_valid_low", 32'(mem_wr_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_err_sticky", 32'(err), 32'd3);
        chk("bp_no_done", done_cnt - d0, 32'd0);

        // Timeout abort mid-word
        d0 = done_cnt;
        w0 = 32'(wa.size());
        send_hdr(32'h0000_0300, 8'd1);
        send_b(8'hA1);
        send_b(8'hA2);
        rx_block_timeout = 1'b1;
        tick();
        rx_block_timeout = 1'b0;
        tick();
        chk("to_err", 32'(err), 32'd2);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_no_write", 32'(wa.size()) - w0, 32'd0);
        chk("to_no_done", done_cnt - d0, 32'd0);
        send_b(8'h02);
        chk("to_clear_err", 32'(err), 32'd0);
        chk("to_run", 32'(cpu_rst), 32'd0);

        // Timeout and byte together in IDLE: byte dropped, timeout ignored
        d0 = done_cnt;
        rx_data = 8'h7F; rx_data_valid = 1'b1; rx_block_timeout = 1'b1;
        tick();
        rx_data_valid = 1'b0; rx_block_timeout = 1'b0;
        tick();
        chk("both_err", 32'(err), 32'd0);
        chk("both_busy", 32'(busy), 32'd0);

        // Bad opcode
        send_b(8'h7F);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_no_done", done_cnt - d0, 32'd0);
        chk("bad_cpu_rst", 32'(cpu_rst), 32'd0);

        // N=0 means 256 words; address wraps past 0xFFFFFFFC
        d0 = done_cnt;
        w0 = 32'(wa.size());
        send_hdr(32'hFFFF_FFFC, 8'd0);
        chk("wrap_err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({~b, 8'h5A, 8'hA5, b});
        end
`ifdef UART_LOAD_CHECKSUM_EN
        send_b(tb_csum);
`endif
        tick();
        chk("wrap_count", 32'(wa.size()) - w0, 32'd256);
        chk("wrap_addr0", wa[w0], 32'hFFFF_FFFC);
        chk("wrap_addr1", wa[w0+1], 32'h0000_0000);
        chk("wrap_data0", wd[w0], 32'hFF5A_A500);
        chk("wrap_addr_last", wa[w0+255], 32'h0000_03F8);
        chk("wrap_data_last", wd[w0+255], 32'h005A_A5FF);
        chk("wrap_done", done_cnt - d0, 32'd1);
        chk("wrap_busy", 32'(busy), 32'd0);

`ifdef UART_LOAD_CHECKSUM_EN
        // Corrupted checksum
        d0 = done_cnt;
        send_hdr(32'h0000_0400, 8'd1);
        send_word(32'h1234_5678);
        send_b(tb_csum ^ 8'h01);
        tick();
        chk("csum_bad_err", 32'(err), 32'd3);
        chk("csum_bad_no_done", done_cnt - d0, 32'd0);
        chk("csum_bad_idle", 32'(busy), 32'd0);
`else
        // Without the checksum a following byte is a fresh opcode
        send_b(8'h03);
        chk("post_write_opcode", 32'(cpu_rst), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
